delay_meas: RTL and testbench
=============================

Name: delay_meas

Overview:
- Measuring counterpart of the CRG delay generator. Counts clock cycles from a trigger pulse to the first high sample of a delayed level signal, such as a delay_gen `out`.
- Presents the result over a valid/ready handshake and tracks the worst-case delay seen.
- Used in the CRG to check reset-release and clock-settle delays, and as a self-check harness for delay_gen instances.

Parameters:
- MAX_COUNT, 128, saturation limit of the measured delay in cycles; must be ≥ 2.
- CW, $clog2(MAX_COUNT+1), derived result width; not to be overridden.

Ports:
- clk  input  1  clock
- arst_n  input  1  synchronous active-low reset, sampled on rising clk
- clear  input  1  synchronous soft clear: abort measurement, zero max_seen
- trig  input  1  start-of-measurement pulse
- dly_in  input  1  delayed level signal under measurement
- busy  output  1  high in MEAS or DONE
- meas_valid  output  1  result available
- meas_ready  input  1  consumer accepts result
- meas_value  output  CW  measured delay in cycles
- meas_timeout  output  1  qualifies meas_value: delay reached MAX_COUNT without dly_in high
- max_seen  output  CW  largest meas_value accepted since reset/clear

Behaviour:
- Reset (arst_n=0 at a clk edge):
  - state=IDLE, counter=0.
  - meas_valid=0, meas_value=0, meas_timeout=0, max_seen=0, busy=0.
  - Reset mid-measurement discards the measurement with no output.
- States: IDLE, MEAS, DONE. All outputs are registered.
- IDLE:
  - trig sampled 1 at edge k → MEAS, counter=0.
  - dly_in is ignored.
- MEAS:
  - Each edge: counter += 1 (saturating at MAX_COUNT).
  - If dly_in is sampled 1 at edge k+N with N ≥ 1 → meas_value=N, meas_timeout=0, meas_valid=1, state DONE.
  - dly_in is level-qualified. If dly_in is already high at edge k+1, the result is N=1.
  - If N reaches MAX_COUNT without dly_in high → meas_value=MAX_COUNT, meas_timeout=1, DONE.
  - Exactly at N=MAX_COUNT: dly_in=1 gives timeout=0.
  - trig is ignored in MEAS; re-triggers are dropped.
- DONE:
  - meas_valid, meas_value and meas_timeout are held stable until meas_valid & meas_ready.
  - On acceptance: meas_valid drops the next cycle and max_seen = max(max_seen, meas_value).
  - A timeout result also updates max_seen, to MAX_COUNT.
  - Next state on acceptance is IDLE, or MEAS with counter=0 if trig=1 in the same cycle (back-to-back, no idle bubble).
  - trig without acceptance is ignored.
- clear:
  - Highest priority after reset. Any state → IDLE.
  - meas_valid=0, max_seen=0; meas_value and meas_timeout retain their values.
  - clear & trig in the same cycle: clear wins and trig is dropped.
- busy = (state != IDLE), registered with the state.
- Width rules:
  - The counter never wraps; it saturates at MAX_COUNT.
  - The comparison for max_seen is unsigned CW-bit.
- meas_ready is ignored when meas_valid=0.

Decomposition:
- delay_meas_pkg:
  - typedef enum logic [1:0] {IDLE, MEAS, DONE} delay_meas_state_e.
  - Function cw_f(max_count) returning $clog2(max_count+1), shared with delay_gen.
- No sub-module. The block is a single FSM, counter and max register, about 150 lines of RTL.
- The bench instantiates delay_gen driving dly_in for the closed-loop scenario.

Test Plan:
- Reset: drive arst_n=0 for 3 cycles while dly_in=1 and trig=1 → all outputs 0, busy=0; after release with trig=0, stays IDLE.
- Basic measurement: trig at edge 10, dly_in rises before edge 15 → meas_valid=1 after edge 15, meas_value=5, timeout=0. Hold meas_ready=0 for 4 cycles → value stable. Assert meas_ready → max_seen=5 next cycle.
- Boundary and timeout (MAX_COUNT=8):
  - dly_in held 1 at trig+1 → value=1.
  - dly_in first high at trig+8 → value=8, timeout=0.
  - dly_in never high → value=8, timeout=1, max_seen=8 after accept.
- Back-to-back and ignored triggers:
  - Results 7 then 3 with trig coincident with the accept of the first → second MEAS starts with no idle cycle; max_seen stays 7.
  - trig pulses during MEAS → no effect on the value.
- clear:
  - clear during MEAS at count 4 → IDLE, no meas_valid.
  - clear & trig together → stays IDLE.
  - clear in DONE → meas_valid drops, max_seen=0.
- Closed loop with delay_gen:
  - delay_gen count_range=16, released in the cycle trig is sampled.
  - meas_value must equal delay_gen's documented assertion latency.
  - Repeat for count_range in {2, 64, 128}, with MAX_COUNT=128.

Source files
------------

// File: rtl/delay_meas_pkg.sv
// Shared types and helpers for the delay measurement block.
package delay_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DONE = 2'd2
  } delay_meas_state_e;

  // Result/counter width able to hold max_count itself; also used by delay_gen.
  function automatic int unsigned cw_f(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/delay_meas.sv
// Measures cycles from a trig pulse to the first high sample of dly_in, presents the
// result over a valid/ready handshake and tracks the largest accepted result.
module delay_meas
  import delay_meas_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 128,
  parameter int unsigned CW        = cw_f(MAX_COUNT)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          clear,
  input  logic          trig,
  input  logic          dly_in,
  output logic          busy,
  output logic          meas_valid,
  input  logic          meas_ready,
  output logic [CW-1:0] meas_value,
  output logic          meas_timeout,
  output logic [CW-1:0] max_seen
);

  localparam logic [CW-1:0] MaxCnt = CW'(MAX_COUNT);

  delay_meas_state_e state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [CW-1:0]     value_q, value_d;
  logic              timeout_q, timeout_d;
  logic [CW-1:0]     max_q, max_d;
  logic              busy_q;
  logic [CW-1:0]     cnt_inc;

  // cnt_q stays below MaxCnt while measuring, so the increment never wraps.
  assign cnt_inc = cnt_q + 1'b1;

  // Next-state logic: clear overrides everything, then the per-state behaviour.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    value_d   = value_q;
    timeout_d = timeout_q;
    max_d     = max_q;

    if (clear) begin
      // Result value/timeout are deliberately retained; only the handshake drops.
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      max_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_d = MEAS;
            cnt_d   = '0;
          end
        end
        MEAS: begin
          if (dly_in) begin
            // A high sample exactly at MaxCnt still counts as a real result.
            state_d   = DONE;
            cnt_d     = cnt_inc;
            value_d   = cnt_inc;
            timeout_d = 1'b0;
            valid_d   = 1'b1;
          end else if (cnt_inc == MaxCnt) begin
            state_d   = DONE;
            cnt_d     = MaxCnt;
            value_d   = MaxCnt;
            timeout_d = 1'b1;
            valid_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DONE: begin
          if (valid_q && meas_ready) begin
            valid_d = 1'b0;
            if (value_q > max_q) begin
              max_d = value_q;
            end
            // A trig coincident with acceptance starts the next run with no bubble.
            if (trig) begin
              state_d = MEAS;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      value_q   <= '0;
      timeout_q <= 1'b0;
      max_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      value_q   <= value_d;
      timeout_q <= timeout_d;
      max_q     <= max_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign busy         = busy_q;
  assign meas_valid   = valid_q;
  assign meas_value   = value_q;
  assign meas_timeout = timeout_q;
  assign max_seen     = max_q;

endmodule

// File: tb/tb_delay_meas.sv
// Self-checking bench for delay_meas: a MAX_COUNT=8 instance for boundary/handshake
// scenarios and a MAX_COUNT=128 instance in closed loop with a delay generator model.
module tb_delay_meas;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n, clear;
  logic       trig_a, dly_a, ready_a, busy_a, valid_a, tmo_a;
  logic [3:0] value_a, max_a;
  logic       trig_b, dly_b, ready_b, busy_b, valid_b, tmo_b;
  logic [7:0] value_b, max_b;

  delay_meas #(.MAX_COUNT(8)) u_dut_a (
    .clk          (clk),
    .arst_n       (arst_n),
    .clear        (clear),
    .trig         (trig_a),
    .dly_in       (dly_a),
    .busy         (busy_a),
    .meas_valid   (valid_a),
    .meas_ready   (ready_a),
    .meas_value   (value_a),
    .meas_timeout (tmo_a),
    .max_seen     (max_a)
  );

  delay_meas #(.MAX_COUNT(128)) u_dut_b (
    .clk          (clk),
    .arst_n       (arst_n),
    .clear        (clear),
    .trig         (trig_b),
    .dly_in       (dly_b),
    .busy         (busy_b),
    .meas_valid   (valid_b),
    .meas_ready   (ready_b),
    .meas_value   (value_b),
    .meas_timeout (tmo_b),
    .max_seen     (max_b)
  );

  // Behavioural stand-in for delay_gen: released at edge k, its output is first
  // sampled high at edge k+gen_range, so the expected measurement is gen_range.
  logic gen_rel = 1'b0;
  logic gen_out = 1'b0;
  int   gen_cnt = 0;
  int   gen_range = 16;
  assign dly_b = gen_out;

  always @(posedge clk) begin
    if (gen_rel) begin
      gen_cnt <= 1;
      gen_out <= (gen_range <= 1);
    end else if (gen_cnt != 0) begin
      gen_cnt <= gen_cnt + 1;
      gen_out <= (gen_cnt + 1 >= gen_range);
    end
  end

  typedef struct packed {
    logic [7:0] v;
    logic       t;
  } exp_t;

  exp_t       sb_a[$];
  exp_t       sb_b[$];
  exp_t       e;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] max_a_m = 8'd0;
  logic [7:0] max_b_m = 8'd0;
  logic [7:0] last_a  = 8'd0;
  bit         ok;

  task automatic step();
    @(negedge clk);
  endtask

  // Stimulus for DUT A: trig now, dly_in first high at trig+n (n=0: never).
  task automatic launch_a(input int n, input bit pre_high);
    exp_t x;
    trig_a = 1'b1;
    dly_a  = pre_high;
    step();
    trig_a = 1'b0;
    if (n == 0) begin
      x.v   = 8'd8;
      x.t   = 1'b1;
      dly_a = 1'b0;
    end else begin
      x.v = 8'(n);
      x.t = 1'b0;
      if (!pre_high) dly_a = 1'b0;
      repeat (n - 1) step();
      dly_a = 1'b1;
    end
    sb_a.push_back(x);
  endtask

  task automatic accept_a(input bit with_trig);
    ready_a = 1'b1;
    trig_a  = with_trig;
    dly_a   = 1'b0;
    step();
    ready_a = 1'b0;
    trig_a  = 1'b0;
    if (last_a > max_a_m) max_a_m = last_a;
  endtask

  task automatic wait_valid(input bit sel_b, input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (sel_b ? valid_b : valid_a) begin
        found = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0; trig_a = 1'b1; dly_a = 1'b1; trig_b = 1'b1;
    repeat (3) step();
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    checks++; if (value_a !== 4'd0) begin errors++; $display("FAIL reset_value: got %0d want 0", value_a); end
    checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", tmo_a); end
    checks++; if (max_a !== 4'd0) begin errors++; $display("FAIL reset_max: got %0d want 0", max_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
    checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b want 0", valid_b); end
    arst_n = 1'b1; trig_a = 1'b0; dly_a = 1'b0; trig_b = 1'b0;
    repeat (3) step();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", valid_a); end
  endtask

  task automatic test_basic();
    launch_a(5, 1'b0);
    wait_valid(1'b0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_wait: got no valid want valid"); end
    e = sb_a.pop_front(); last_a = e.v;
    checks++; if (8'(value_a) !== e.v) begin errors++; $display("FAIL basic_value: got %0d want %0d", value_a, e.v); end
    checks++; if (tmo_a !== e.t) begin errors++; $display("FAIL basic_timeout: got %b want %b", tmo_a, e.t); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (valid_a !== 1'b1 || 8'(value_a) !== e.v) begin
        errors++; $display("FAIL basic_hold: got v=%b val=%0d want v=1 val=%0d", valid_a, value_a, e.v);
      end
    end
    accept_a(1'b0);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL basic_drop: got %b want 0", valid_a); end
    checks++; if (8'(max_a) !== max_a_m) begin errors++; $display("FAIL basic_max: got %0d want %0d", max_a, max_a_m); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy_a); end
  endtask

  task automatic test_boundary();
    // Each entry: {n, pre_high}; n=0 means dly_in never rises.
    int n_tab[3] = '{1, 0, 8};
    bit p_tab[3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      launch_a(n_tab[i], p_tab[i]);
      wait_valid(1'b0, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bound_wait[%0d]: got no valid want valid", i); end
      e = sb_a.pop_front(); last_a = e.v;
      checks++; if (8'(value_a) !== e.v) begin errors++; $display("FAIL bound_value[%0d]: got %0d want %0d", i, value_a, e.v); end
      checks++; if (tmo_a !== e.t) begin errors++; $display("FAIL bound_timeout[%0d]: got %b want %b", i, tmo_a, e.t); end
      accept_a(1'b0);
      checks++; if (8'(max_a) !== max_a_m) begin errors++; $display("FAIL bound_max[%0d]: got %0d want %0d", i, max_a, max_a_m); end
    end
  endtask

  task automatic test_clear();
    trig_a = 1'b1; step(); trig_a = 1'b0;
    repeat (3) step();
    clear = 1'b1; step(); clear = 1'b0; max_a_m = 8'd0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL clr_meas_busy: got %b want 0", busy_a); end
    checks++; if (8'(max_a) !== max_a_m) begin errors++; $display("FAIL clr_meas_max: got %0d want 0", max_a); end
    dly_a = 1'b1; repeat (3) step(); dly_a = 1'b0;
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL clr_meas_valid: got %b want 0", valid_a); end
    clear = 1'b1; trig_a = 1'b1; step(); clear = 1'b0; trig_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL clr_trig_busy: got %b want 0", busy_a); end
    step();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL clr_trig_busy2: got %b want 0", busy_a); end
    launch_a(3, 1'b0);
    wait_valid(1'b0, 20, ok);
    e = sb_a.pop_front(); last_a = e.v;
    checks++; if (!ok || 8'(value_a) !== e.v) begin errors++; $display("FAIL clr_pre_value: got %0d want %0d", value_a, e.v); end
    accept_a(1'b0);
    checks++; if (8'(max_a) !== max_a_m) begin errors++; $display("FAIL clr_pre_max: got %0d want %0d", max_a, max_a_m); end
    launch_a(2, 1'b0);
    wait_valid(1'b0, 20, ok);
    e = sb_a.pop_front();
    checks++; if (!ok || 8'(value_a) !== e.v) begin errors++; $display("FAIL clr_done_value: got %0d want %0d", value_a, e.v); end
    clear = 1'b1; step(); clear = 1'b0; max_a_m = 8'd0;
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL clr_done_valid: got %b want 0", valid_a); end
    checks++; if (8'(max_a) !== max_a_m) begin errors++; $display("FAIL clr_done_max: got %0d want 0", max_a); end
    checks++; if (8'(value_a) !== e.v || tmo_a !== e.t) begin
      errors++; $display("FAIL clr_done_retain: got %0d/%b want %0d/%b", value_a, tmo_a, e.v, e.t);
    end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL clr_done_busy: got %b want 0", busy_a); end
    dly_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t x;
    launch_a(7, 1'b0);
    wait_valid(1'b0, 20, ok);
    e = sb_a.pop_front(); last_a = e.v;
    checks++; if (!ok || 8'(value_a) !== e.v) begin errors++; $display("FAIL b2b_first: got %0d want %0d", value_a, e.v); end
    accept_a(1'b1);
    checks++; if (busy_a !== 1'b1 || valid_a !== 1'b0) begin
      errors++; $display("FAIL b2b_no_bubble: got busy=%b valid=%b want busy=1 valid=0", busy_a, valid_a);
    end
    x.v = 8'd3; x.t = 1'b0; sb_a.push_back(x);
    repeat (2) step();
    dly_a = 1'b1;
    wait_valid(1'b0, 20, ok);
    e = sb_a.pop_front(); last_a = e.v;
    checks++; if (!ok || 8'(value_a) !== e.v) begin errors++; $display("FAIL b2b_second: got %0d want %0d", value_a, e.v); end
    accept_a(1'b0);
    checks++; if (8'(max_a) !== max_a_m) begin errors++; $display("FAIL b2b_max: got %0d want %0d", max_a, max_a_m); end
  endtask

  task automatic test_ignored_trig();
    exp_t x;
    trig_a = 1'b1; dly_a = 1'b0; step(); trig_a = 1'b0;
    step();
    trig_a = 1'b1; step(); trig_a = 1'b0;
    step();
    dly_a = 1'b1;
    x.v = 8'd4; x.t = 1'b0; sb_a.push_back(x);
    wait_valid(1'b0, 20, ok);
    e = sb_a.pop_front(); last_a = e.v;
    checks++; if (!ok || 8'(value_a) !== e.v) begin errors++; $display("FAIL retrig_value: got %0d want %0d", value_a, e.v); end
    accept_a(1'b0);
    checks++; if (8'(max_a) !== max_a_m) begin errors++; $display("FAIL retrig_max: got %0d want %0d", max_a, max_a_m); end
  endtask

  task automatic test_closed_loop();
    int   r_tab[4] = '{16, 2, 64, 128};
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      gen_range = r_tab[i];
      trig_b = 1'b1; gen_rel = 1'b1; step(); trig_b = 1'b0; gen_rel = 1'b0;
      x.v = 8'(r_tab[i]); x.t = 1'b0; sb_b.push_back(x);
      wait_valid(1'b1, 200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL loop_wait[%0d]: got no valid want valid", r_tab[i]); end
      e = sb_b.pop_front();
      checks++; if (value_b !== e.v || tmo_b !== e.t) begin
        errors++; $display("FAIL loop_value[%0d]: got %0d/%b want %0d/%b", r_tab[i], value_b, tmo_b, e.v, e.t);
      end
      ready_b = 1'b1; step(); ready_b = 1'b0;
      if (e.v > max_b_m) max_b_m = e.v;
    end
    checks++; if (max_b !== max_b_m) begin errors++; $display("FAIL loop_max: got %0d want %0d", max_b, max_b_m); end
  endtask

  initial begin
    arst_n = 1'b0; clear = 1'b0;
    trig_a = 1'b0; dly_a = 1'b0; ready_a = 1'b0;
    trig_b = 1'b0; ready_b = 1'b0;
    step();
    test_reset();
    test_basic();
    test_boundary();
    test_clear();
    test_back_to_back();
    test_ignored_trig();
    test_closed_loop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
